// File: rtl/serial_pair_tx_pkg.sv
// Shared types and sizing helpers for the serial pair transmitter.
package serial_pair_tx_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Bit-counter width; never below one bit so the counter is always declarable.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_pair_transmitter_shift_reg.sv
// W-bit load/shift register with a registered serial output, one per operand.
// Shift direction: MSB first by default, LSB first when SERIAL_PAIR_TX_LSB_FIRST_EN is defined.
module serial_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         serial_out
);

    logic [W-1:0] sr_q;
    logic         bit_q;

    // The first bit goes straight to the output register; sr_q keeps the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            bit_q <= 1'b0;
        end else if (load) begin
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
            bit_q <= data[0];
            sr_q  <= data >> 1;
`else
            bit_q <= data[W-1];
            sr_q  <= data << 1;
`endif
        end else if (shift) begin
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
            bit_q <= sr_q[0];
            sr_q  <= sr_q >> 1;
`else
            bit_q <= sr_q[W-1];
            sr_q  <= sr_q << 1;
`endif
        end else begin
            bit_q <= 1'b0;
        end
    end

    assign serial_out = bit_q;

endmodule

// File: rtl/serial_pair_transmitter_msb_first.sv
// Operand-pair parallel-to-serial transmitter with valid/ready input and framed serial output.
// Bit order follows serial_shift_reg (SERIAL_PAIR_TX_LSB_FIRST_EN selects LSB first).
module serial_pair_transmitter_msb_first
    import serial_pair_tx_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last,
    output logic         a,
    output logic         b
);

    localparam int unsigned     CntW   = cnt_width(W);
    localparam logic [CntW-1:0] CntMax = CntW'(W - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;
    logic            handshake;
    logic            shift;
    logic            a_bit;
    logic            b_bit;

    assign at_last   = (state_q == StShift) && (cnt_q == CntMax);
    // Ready on the last bit too, so a new word follows with no bubble.
    assign in_ready  = !rst && ((state_q == StIdle) || at_last);
    assign handshake = in_valid && in_ready;
    assign shift     = (state_q == StShift) && !at_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (at_last) begin
                    cnt_d   = '0;
                    state_d = handshake ? StShift : StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_shift_reg #(
        .W (W)
    ) u_shift_a (
        .clk        (clk),
        .rst        (rst),
        .load       (handshake),
        .shift      (shift),
        .data       (in_a),
        .serial_out (a_bit)
    );

    serial_shift_reg #(
        .W (W)
    ) u_shift_b (
        .clk        (clk),
        .rst        (rst),
        .load       (handshake),
        .shift      (shift),
        .data       (in_b),
        .serial_out (b_bit)
    );

    assign out_valid = (state_q == StShift);
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = at_last;
    assign a         = out_valid && a_bit;
    assign b         = out_valid && b_bit;

endmodule

// File: tb/tb_serial_pair_transmitter_msb_first.sv
// Self-checking bench: vector table plus hand-written back-to-back, busy and reset sequences.
module tb_serial_pair_transmitter_msb_first;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] in_a;
        logic [W-1:0] in_b;
        logic [W-1:0] seq_a;   // bit W-1 is the first bit expected on the wire
        logic [W-1:0] seq_b;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic first;
        logic last;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         a;
    logic         b;

    logic [W-1:0] exp_seq_a = '0;
    logic [W-1:0] exp_seq_b = '0;
    exp_bit_t     exp_q[$];
    exp_bit_t     mon_e;
    logic         mon_rdy;
    logic         mon_en = 1'b0;
    logic         exp_valid_next = 1'b0;
    int           n_compared = 0;
    int           n_mismatched = 0;
    int           n_first = 0;
    int           n_last = 0;
    vec_t         vecs[5];

    serial_pair_transmitter_msb_first #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .a         (a),
        .b         (b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] order(input logic [W-1:0] v);
        logic [W-1:0] r;
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
`else
        r = v;
`endif
        return r;
    endfunction

    // Monitor: scoreboard of bit pairs plus a cycle model of out_valid and in_ready.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid_next});
            if (out_valid) begin
                if (out_first) n_first++;
                if (out_last) n_last++;
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_bit: got a valid bit pair, expected none at %0t",
                             $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("a", {31'd0, a}, {31'd0, mon_e.a});
                    check("b", {31'd0, b}, {31'd0, mon_e.b});
                    check("out_first", {31'd0, out_first}, {31'd0, mon_e.first});
                    check("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
                end
            end else begin
                check("idle_outputs", {28'd0, a, b, out_first, out_last}, 32'd0);
            end
            mon_rdy = !rst && (!out_valid || out_last);
            check("in_ready", {31'd0, in_ready}, {31'd0, mon_rdy});
            exp_valid_next = !rst && ((out_valid && !out_last) || (in_valid && mon_rdy));
            if (in_valid && mon_rdy) begin
                for (int i = W - 1; i >= 0; i--) begin
                    exp_q.push_back('{a: exp_seq_a[i], b: exp_seq_b[i],
                                      first: (i == W - 1), last: (i == 0)});
                end
            end
            if (rst) exp_q.delete();
        end
    end

    // Called just after a posedge; returns just after the handshake edge.
    task automatic send_word(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [W-1:0] sa, input logic [W-1:0] sb);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_a      = va;
        in_b      = vb;
        exp_seq_a = order(sa);
        exp_seq_b = order(sb);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL handshake_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        int l0;
        vecs[0] = '{in_a: 8'hA5, in_b: 8'h5A, seq_a: 8'hA5, seq_b: 8'h5A};
        vecs[1] = '{in_a: 8'h01, in_b: 8'h80, seq_a: 8'h01, seq_b: 8'h80};
        vecs[2] = '{in_a: 8'hFF, in_b: 8'h00, seq_a: 8'hFF, seq_b: 8'h00};
        vecs[3] = '{in_a: 8'h3C, in_b: 8'h3D, seq_a: 8'h3C, seq_b: 8'h3D};
        vecs[4] = '{in_a: 8'h80, in_b: 8'h7F, seq_a: 8'h80, seq_b: 8'h7F};

        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Table-driven single words with idle gaps.
        for (int i = 0; i < 5; i++) begin
            f0 = n_first;
            l0 = n_last;
            send_word(vecs[i].in_a, vecs[i].in_b, vecs[i].seq_a, vecs[i].seq_b);
            idle(W + 2);
            check("first_count", n_first - f0, 1);
            check("last_count", n_last - l0, 1);
        end

        // Back-to-back words with in_valid held high.
        f0 = n_first;
        send_word(8'hFF, 8'h00, 8'hFF, 8'h00);
        send_word(8'h00, 8'hFF, 8'h00, 8'hFF);
        idle(2 * W + 2);
        check("b2b_first_count", n_first - f0, 2);

        // New word offered while bit 3 of the current word is on the wire.
        send_word(8'h96, 8'h69, 8'h96, 8'h69);
        idle(4);
        send_word(8'h5F, 8'hF5, 8'h5F, 8'hF5);
        idle(W + 2);

        // One-cycle reset while bit 3 is on the wire aborts the word.
        send_word(8'hC3, 8'h3C, 8'hC3, 8'h3C);
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        f0 = n_first;
        send_word(8'hA5, 8'h5A, 8'hA5, 8'h5A);
        idle(W + 2);
        check("post_reset_first", n_first - f0, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
